// File: rtl/odd_pipe_pkg.sv
// Shared types and constants for the odd-pipe (Permute / LocalStore / Branch) issue scoreboard.
package odd_pipe_pkg;

    localparam int SB_ADDR_W = 7;
    localparam int SB_DEPTH  = 7;
    localparam int SEL_W     = 3;

    // Age at which each unit's result first appears in a forward slot
    localparam int LAT_PERM = 4;
    localparam int LAT_LS   = 6;
    localparam int LAT_BR   = 1;

    localparam logic [SEL_W-1:0] FWSEL_RF = 3'd0;
    localparam logic [SEL_W-1:0] FWSEL_WB = 3'd7;

    typedef enum logic [1:0] {
        PERM  = 2'd0,
        LS    = 2'd1,
        BR    = 2'd2,
        UNDEF = 2'd3
    } unit_t;

    typedef logic [SEL_W-1:0] lat_t;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        lat_t                 lat;
    } sb_entry_t;

    function automatic lat_t unit_lat(unit_t u);
        case (u)
            LS:      return lat_t'(LAT_LS);
            BR:      return lat_t'(LAT_BR);
            default: return lat_t'(LAT_PERM);
        endcase
    endfunction

endpackage

// File: rtl/src_hazard_match.sv
// One source operand vs. the in-flight write array: youngest matching write decides
// whether the operand is forwardable yet and from which slot.
module src_hazard_match
    import odd_pipe_pkg::*;
(
    input  logic [SB_ADDR_W-1:0]    src_addr,
    input  logic                    src_vld,
    input  sb_entry_t [SB_DEPTH:1]  ent,
    output logic                    ready,
    output logic [SEL_W-1:0]        sel
);

    logic hit;

    always_comb begin
        hit   = 1'b0;
        ready = 1'b1;
        sel   = FWSEL_RF;
        // Scan from youngest age; an older write to the same register is shadowed
        for (int k = 1; k <= SB_DEPTH; k++) begin
            if (!hit && src_vld && ent[k].valid && (ent[k].addr == src_addr)) begin
                hit = 1'b1;
                if (k < int'(ent[k].lat))
                    ready = 1'b0;
                else
                    sel = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/odd_hazard_scoreboard.sv
// Odd-pipe RAW scoreboard and forward-select controller for the dual-issue pair.
// Define ODD_SB_STATS_EN to add saturating stall_cycles / issued_count counters.
module odd_hazard_scoreboard
    import odd_pipe_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DEPTH  = SB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              odd_valid,
    input  logic [1:0]        odd_unit,
    input  logic              odd_reg_write,
    input  logic [ADDR_W-1:0] odd_rt_addr,
    input  logic [ADDR_W-1:0] ra_odd_addr,
    input  logic [ADDR_W-1:0] rb_odd_addr,
    input  logic [ADDR_W-1:0] ra_even_addr,
    input  logic [ADDR_W-1:0] rb_even_addr,
    input  logic [ADDR_W-1:0] rc_even_addr,
    input  logic              is_ra_odd_valid,
    input  logic              is_rb_odd_valid,
    input  logic              is_ra_even_valid,
    input  logic              is_rb_even_valid,
    input  logic              is_rc_even_valid,
    input  logic              flush_young,
    output logic              stall_odd_raw,
    output logic              stall_even_raw,
    output logic              issue_fire,
    output logic [2:0]        sel_ra_odd,
    output logic [2:0]        sel_rb_odd,
    output logic [2:0]        sel_ra_even,
    output logic [2:0]        sel_rb_even,
    output logic [2:0]        sel_rc_even
`ifdef ODD_SB_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       issued_count
`endif
);

    localparam int NSRC = 5;

    sb_entry_t [DEPTH:1]                ent;
    sb_entry_t                          new_ent;
    logic [NSRC-1:0][ADDR_W-1:0]        src_addr;
    logic [NSRC-1:0]                    src_vld;
    logic [NSRC-1:0]                    src_rdy;
    logic [NSRC-1:0][SEL_W-1:0]         src_sel;

    // Index order: 0 ra_odd, 1 rb_odd, 2 ra_even, 3 rb_even, 4 rc_even
    assign src_addr = {rc_even_addr, rb_even_addr, ra_even_addr, rb_odd_addr, ra_odd_addr};
    assign src_vld  = {is_rc_even_valid, is_rb_even_valid, is_ra_even_valid,
                       is_rb_odd_valid, is_ra_odd_valid};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        src_hazard_match u_match (
            .src_addr (src_addr[i]),
            .src_vld  (src_vld[i]),
            .ent      (ent),
            .ready    (src_rdy[i]),
            .sel      (src_sel[i])
        );
    end

    assign stall_odd_raw  = ~(src_rdy[0] & src_rdy[1]);
    assign stall_even_raw = ~(&src_rdy[4:2]);
    assign issue_fire     = odd_valid & ~stall_odd_raw & ~stall_even_raw & ~flush_young;

    assign sel_ra_odd  = src_sel[0];
    assign sel_rb_odd  = src_sel[1];
    assign sel_ra_even = src_sel[2];
    assign sel_rb_even = src_sel[3];
    assign sel_rc_even = src_sel[4];

    always_comb begin
        new_ent = '0;
        if (issue_fire && odd_reg_write && !flush_young) begin
            new_ent.valid = 1'b1;
            new_ent.addr  = odd_rt_addr;
            new_ent.lat   = unit_lat(unit_t'(odd_unit));
        end
    end

    // Ages advance every cycle regardless of stalls; a kill drops the age-1 write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent <= '0;
        end else begin
            ent[1] <= new_ent;
            ent[2] <= flush_young ? '0 : ent[1];
            for (int k = 3; k <= DEPTH; k++)
                ent[k] <= ent[k-1];
        end
    end

`ifdef ODD_SB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            issued_count <= '0;
        end else begin
            if (odd_valid && !issue_fire && !flush_young && !(&stall_cycles))
                stall_cycles <= stall_cycles + 32'd1;
            if (issue_fire && !(&issued_count))
                issued_count <= issued_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_odd_hazard_scoreboard.sv
// Bench for odd_hazard_scoreboard: directed vector table, reset-mid-stall sequence,
// then random traffic against a timestamp-based model of in-flight writes.
module tb_odd_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       odd_valid, odd_reg_write, flush_young;
    logic [1:0] odd_unit;
    logic [6:0] odd_rt_addr, ra_odd_addr, rb_odd_addr, ra_even_addr, rb_even_addr, rc_even_addr;
    logic       is_ra_odd_valid, is_rb_odd_valid, is_ra_even_valid, is_rb_even_valid, is_rc_even_valid;
    logic       stall_odd_raw, stall_even_raw, issue_fire;
    logic [2:0] sel_ra_odd, sel_rb_odd, sel_ra_even, sel_rb_even, sel_rc_even;
`ifdef ODD_SB_STATS_EN
    logic [31:0] stall_cycles, issued_count;
`endif

    odd_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .odd_valid(odd_valid), .odd_unit(odd_unit),
        .odd_reg_write(odd_reg_write), .odd_rt_addr(odd_rt_addr),
        .ra_odd_addr(ra_odd_addr), .rb_odd_addr(rb_odd_addr),
        .ra_even_addr(ra_even_addr), .rb_even_addr(rb_even_addr), .rc_even_addr(rc_even_addr),
        .is_ra_odd_valid(is_ra_odd_valid), .is_rb_odd_valid(is_rb_odd_valid),
        .is_ra_even_valid(is_ra_even_valid), .is_rb_even_valid(is_rb_even_valid),
        .is_rc_even_valid(is_rc_even_valid), .flush_young(flush_young),
        .stall_odd_raw(stall_odd_raw), .stall_even_raw(stall_even_raw), .issue_fire(issue_fire),
        .sel_ra_odd(sel_ra_odd), .sel_rb_odd(sel_rb_odd), .sel_ra_even(sel_ra_even),
        .sel_rb_even(sel_rb_even), .sel_rc_even(sel_rc_even)
`ifdef ODD_SB_STATS_EN
        , .stall_cycles(stall_cycles), .issued_count(issued_count)
`endif
    );

    always #5 clk = ~clk;

    logic [17:0] dut_vec;
    assign dut_vec = {stall_odd_raw, stall_even_raw, issue_fire,
                      sel_ra_odd, sel_rb_odd, sel_ra_even, sel_rb_even, sel_rc_even};

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: writes tagged with their issue cycle ----------------
    typedef struct { logic [6:0] addr; int lat; int t; bit dead; } wr_t;
    wr_t q[$];
    int  cyc = 0;
    int  m_stall = 0;
    int  m_issued = 0;

    function automatic int lat_of(logic [1:0] u);
        case (u)
            2'd1:    return 6;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    function automatic void m_src(input logic f, input logic [6:0] a, output bit rdy, output int sel);
        int best;
        int bl;
        best = 99;
        bl = 0;
        rdy = 1;
        sel = 0;
        if (f) begin
            foreach (q[i]) begin
                int age;
                age = cyc - q[i].t;
                if (!q[i].dead && age >= 1 && age <= 7 && q[i].addr == a && age < best) begin
                    best = age;
                    bl = q[i].lat;
                end
            end
        end
        if (best < 99) begin
            if (best < bl) rdy = 0;
            else sel = best;
        end
    endfunction

    function automatic logic [17:0] m_expect();
        logic [6:0] a[5];
        bit         f[5];
        bit         rdy[5];
        int         s[5];
        bit         so, se, fi;
        a = '{ra_odd_addr, rb_odd_addr, ra_even_addr, rb_even_addr, rc_even_addr};
        f = '{is_ra_odd_valid, is_rb_odd_valid, is_ra_even_valid, is_rb_even_valid, is_rc_even_valid};
        for (int i = 0; i < 5; i++) m_src(f[i], a[i], rdy[i], s[i]);
        so = !rdy[0] || !rdy[1];
        se = !(rdy[2] && rdy[3] && rdy[4]);
        fi = odd_valid && !so && !se && !flush_young;
        return {so, se, fi, 3'(s[0]), 3'(s[1]), 3'(s[2]), 3'(s[3]), 3'(s[4])};
    endfunction

    task automatic m_edge(input bit fi);
        if (flush_young)
            foreach (q[i]) if (cyc - q[i].t == 1) q[i].dead = 1;
        if (fi && odd_reg_write && !flush_young)
            q.push_back('{addr: odd_rt_addr, lat: lat_of(odd_unit), t: cyc, dead: 0});
        if (odd_valid && !fi && !flush_young) m_stall++;
        if (fi) m_issued++;
        cyc++;
        while (q.size() > 0 && cyc - q[0].t > 7) void'(q.pop_front());
    endtask

    // Compare current outputs (table value or model), then clock one edge
    task automatic step(input string nm, input logic [17:0] exp, input bit use_tbl);
        logic [17:0] e;
        #1;
        e = m_expect();
        chk(nm, 32'(dut_vec), 32'(use_tbl ? exp : e));
        @(posedge clk);
        m_edge(e[15]);
        #1;
    endtask

    task automatic set_srcs(input logic [6:0] a, input logic [4:0] f);
        ra_odd_addr = a; rb_odd_addr = a; ra_even_addr = a; rb_even_addr = a; rc_even_addr = a;
        {is_rc_even_valid, is_rb_even_valid, is_ra_even_valid, is_rb_odd_valid, is_ra_odd_valid} = f;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       ov; logic [1:0] unit; logic wr; logic [6:0] rt;
        int         sidx; logic [6:0] sa; logic fl;
        logic       so, se, fi; logic [2:0] sel;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic ov, logic [1:0] unit, logic wr, logic [6:0] rt, int sidx,
                                logic [6:0] sa, logic fl, logic so, logic se, logic fi, logic [2:0] sel);
        vec_t v;
        v = '{ov: ov, unit: unit, wr: wr, rt: rt, sidx: sidx, sa: sa, fl: fl,
              so: so, se: se, fi: fi, sel: sel};
        return v;
    endfunction

    initial begin
        logic [4:0][2:0] es;
        logic [4:0]      fl5;

        odd_valid = 1'b1; odd_unit = 2'd0; odd_reg_write = 1'b0; odd_rt_addr = '0; flush_young = 1'b0;
        set_srcs(7'd0, 5'b11111);
        #12;
        chk("reset state", 32'(dut_vec), 32'({3'b001, 15'd0}));
        odd_valid = 1'b0;
        set_srcs(7'd0, 5'b00000);
        reset = 1'b0;
        @(posedge clk); #1;

        // Perm r5: stalls ages 1-3, forwards from fw4; then drains through fw5..rt_wb
        tbl.push_back(mk(1,0,1,5,  0,5,0, 0,0,1,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0, 0,5,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,  0,5,0, 0,0,1,4));
        tbl.push_back(mk(0,0,0,0,  1,5,0, 0,0,0,5));
        tbl.push_back(mk(0,0,0,0,  2,5,0, 0,0,0,6));
        tbl.push_back(mk(0,0,0,0,  3,5,0, 0,0,0,7));
        // LS r9 read by even rc: even stall holds the odd instruction too
        tbl.push_back(mk(1,1,1,9,  4,5,0, 0,0,1,0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,1,20, 4,9,0, 0,1,0,0));
        tbl.push_back(mk(1,0,1,20, 4,9,0, 0,0,1,6));
        tbl.push_back(mk(0,0,0,0,  4,9,0, 0,0,0,7));
        tbl.push_back(mk(0,0,0,0,  4,9,0, 0,0,0,0));
        // Branch link r0 forwards from fw1
        tbl.push_back(mk(1,2,1,0,  9,0,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0,0,  1,0,0, 0,0,1,1));
        // Perm r3 then Br r3: younger Br governs
        tbl.push_back(mk(1,0,1,3,  9,3,0, 0,0,1,0));
        tbl.push_back(mk(1,2,1,3,  9,3,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0,0,  0,3,0, 0,0,1,1));
        // Kill of age-1 Perm r7; the flushed r8 never enters
        tbl.push_back(mk(1,0,1,7,  9,7,0, 0,0,1,0));
        tbl.push_back(mk(1,0,1,8,  9,8,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,  2,7,0, 0,0,1,0));
        // Unit 3 write to r30 uses Permute latency
        tbl.push_back(mk(1,3,1,30, 3,8,0, 0,0,1,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0, 0,30,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,  0,30,0, 0,0,1,4));

        foreach (tbl[i]) begin
            odd_valid = tbl[i].ov; odd_unit = tbl[i].unit; odd_reg_write = tbl[i].wr;
            odd_rt_addr = tbl[i].rt; flush_young = tbl[i].fl;
            fl5 = (tbl[i].sidx < 5) ? 5'(1 << tbl[i].sidx) : 5'd0;
            set_srcs(tbl[i].sa, fl5);
            es = '0;
            if (tbl[i].sidx < 5) es[4 - tbl[i].sidx] = tbl[i].sel;
            step($sformatf("vec%0d", i), {tbl[i].so, tbl[i].se, tbl[i].fi, es}, 1'b1);
        end

        // Async reset in the middle of an LS stall
        odd_valid = 1'b1; odd_unit = 2'd1; odd_reg_write = 1'b1; odd_rt_addr = 7'd11; flush_young = 1'b0;
        set_srcs(7'd11, 5'b00000);
        step("ls issue", '0, 1'b0);
        odd_reg_write = 1'b0;
        set_srcs(7'd11, 5'b10000);
        step("ls stall1", '0, 1'b0);
        step("ls stall2", '0, 1'b0);
        #1;
        chk("ls stall3", 32'(stall_even_raw), 32'd1);
        reset = 1'b1;
        #1;
        chk("async rst stall", 32'(stall_even_raw), 32'd0);
        chk("async rst fire", 32'(issue_fire), 32'd1);
        chk("async rst sel", 32'(sel_rc_even), 32'd0);
        q.delete();
        m_stall = 0;
        m_issued = 0;
        odd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        set_srcs(7'd11, 5'b11111);
        #1;
        chk("post rst idle", 32'(dut_vec), 32'd0);
        odd_valid = 1'b1;
        #1;
        chk("post rst fire", 32'(dut_vec), 32'({3'b001, 15'd0}));
        step("post rst step", '0, 1'b0);

        // Random traffic over a small register window to force frequent hazards
        for (int n = 0; n < 400; n++) begin
            odd_valid     = ($urandom % 4) != 0;
            odd_unit      = 2'($urandom % 4);
            odd_reg_write = 1'($urandom % 2);
            odd_rt_addr   = 7'($urandom_range(0, 7));
            flush_young   = ($urandom % 8) == 0;
            ra_odd_addr   = 7'($urandom_range(0, 7));
            rb_odd_addr   = 7'($urandom_range(0, 7));
            ra_even_addr  = 7'($urandom_range(0, 7));
            rb_even_addr  = 7'($urandom_range(0, 7));
            rc_even_addr  = 7'($urandom_range(0, 7));
            {is_rc_even_valid, is_rb_even_valid, is_ra_even_valid, is_rb_odd_valid, is_ra_odd_valid}
                = 5'($urandom);
            step($sformatf("rand%0d", n), '0, 1'b0);
        end

`ifdef ODD_SB_STATS_EN
        chk("stall_cycles", stall_cycles, 32'(m_stall));
        chk("issued_count", issued_count, 32'(m_issued));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/odd_hazard_scoreboard.md
Name: odd_hazard_scoreboard

Overview:
- Issue-stage RAW scoreboard and forward-select controller for the odd pipe (Permute, LocalStore, Branch).
- Tracks each in-flight odd-pipe write as it moves through forward slots fw1..fw6 and rt_wb.
- Raises per-slot RAW stalls for the dual-issue pair and drives the forward-mux select for all five source operands, so the odd/even pair issues or holds together.

Parameters:
- ADDR_W, 7, register address width (128-entry RF).
- DEPTH, 7, tracked ages 1..7 (fw1..fw6, then rt_wb).
- LAT_PERM, 4, age at which a Permute result first sits in a forward slot.
- LAT_LS, 6, same for LocalStore.
- LAT_BR, 1, same for Branch link writes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- odd_valid  in  1  odd-slot instruction present in RF/FWD stage.
- odd_unit  in  2  0 Perm, 1 LS, 2 Br, 3 treated as Perm.
- odd_reg_write  in  1  odd instruction writes rt.
- odd_rt_addr  in  ADDR_W  odd destination.
- ra_odd_addr, rb_odd_addr  in  ADDR_W each  odd sources.
- ra_even_addr, rb_even_addr, rc_even_addr  in  ADDR_W each  even sources.
- is_ra_odd_valid, is_rb_odd_valid, is_ra_even_valid, is_rb_even_valid, is_rc_even_valid  in  1 each  source actually read.
- flush_young  in  1  branch_kill: kill the twin/younger instruction.
- stall_odd_raw  out  1  odd source not yet forwardable.
- stall_even_raw  out  1  even source not yet forwardable.
- issue_fire  out  1  pair advances this cycle.
- sel_ra_odd, sel_rb_odd, sel_ra_even, sel_rb_even, sel_rc_even  out  3 each  0 = RF, k = 1..6 = fw_k, 7 = rt_wb.

Behaviour:
- State: DEPTH entries {valid, addr, lat}, indexed by age. Entry age k corresponds to slot fw_k (k ≤ 6) or rt_wb (k = 7).
- Every posedge: all entries shift age k → k+1; age 7 drops out (RF written).
- Age 1 loads {1, odd_rt_addr, lat(odd_unit)} iff issue_fire & odd_reg_write & ~flush_young. Otherwise age 1 loads a bubble (valid = 0).
- flush_young = 1: the entry currently at age 1 is invalidated, not shifted to age 2, in the same edge.
- Match rule: a source matches entry k iff the source's valid flag = 1, entry valid = 1, and addrs are equal. Only the youngest match (lowest k) counts.
- Youngest match with k < lat → source not ready → contributes to its slot's stall.
- Youngest match with k ≥ lat → sel = k.
- No match, or source flag = 0 → sel = 0.
- stall_odd_raw = OR of odd sources not ready. stall_even_raw = OR of even sources not ready.
- issue_fire = odd_valid & ~stall_odd_raw & ~stall_even_raw & ~flush_young.
- Stalls, sels and issue_fire are combinational from current state. Zero-cycle latency to decode.
- Source equal to odd_rt_addr of the same-cycle instruction: no self-hazard (RF read precedes write).
- Unit 3: latency LAT_PERM.
- Reset (asynchronous, any cycle including mid-stall): all entries invalid. Then stalls = 0, sels = 0, issue_fire = odd_valid.
- Same address written twice in flight: the younger write governs, even if the older one is ready.

Optional Feature:
- Macro ODD_SB_STATS_EN.
- When defined: adds outputs stall_cycles (32 bits) and issued_count (32 bits).
  - stall_cycles increments when odd_valid & ~issue_fire & ~flush_young.
  - issued_count increments on issue_fire.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package odd_pipe_pkg holds:
  - unit_t enum (PERM, LS, BR, UNDEF).
  - LAT_* constants.
  - FWSEL_RF = 0, FWSEL_WB = 7.
  - sb_entry_t struct {valid, addr, lat}.
  - function unit_lat(unit_t).
- Sub-module src_hazard_match: one source address + valid flag vs. the entry array → ready, sel. Instantiate five times.

Test Plan:
- Perm to r5 issued at t0; odd ra = r5 at t1 → stall_odd_raw = 1 for t1–t3, issue_fire at t4 with sel_ra_odd = 4.
- LS to r9 at t0; even rc = r9 → stall_even_raw = 1 for t1–t5, odd also held (issue_fire = 0); at t6 sel_rc_even = 6; at t7 sel = 7; at t8 sel = 0.
- Branch link to r0 at t0; odd rb = r0 at t1 → no stall, sel_rb_odd = 1.
- Perm to r3 at t0, Br to r3 at t1; source r3 at t2 → sel = 1 (younger Br wins, ready).
- flush_young with age-1 Perm to r7 → next cycle a source r7 gets sel = 0, no stall.
- Reset asserted at t3 of an LS stall → stall drops asynchronously; after release, sels = 0 and issue_fire follows odd_valid.
